// File: rtl/rr_mux4_stage_pkg.sv
// Shared constants, state encoding and index helper
// for the round-robin 4:1 mux front end.
package rr_mux4_stage_pkg;

   localparam int NUM_SRC = 4;
   localparam int SEL_W = 2;
   localparam logic [SEL_W-1:0] PTR_RESET = 2'd0;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_e;

   function automatic logic [SEL_W-1:0] next_idx(
      input logic [SEL_W-1:0] idx
   );
      return idx + 2'd1;
   endfunction

endpackage

// File: rtl/yMux4to1.sv
// 4:1 word multiplexer; c selects one of a0..a3 onto z.
// Purely combinational.
module yMux4to1 #(
   parameter int SIZE = 32
) (
   output logic [SIZE-1:0] z,
   input  logic [SIZE-1:0] a0,
   input  logic [SIZE-1:0] a1,
   input  logic [SIZE-1:0] a2,
   input  logic [SIZE-1:0] a3,
   input  logic [1:0]      c
);

   always_comb begin
      z = a0;
      unique case (c)
         2'd0: z = a0;
         2'd1: z = a1;
         2'd2: z = a2;
         2'd3: z = a3;
         default: z = a0;
      endcase
   end

endmodule

// File: rtl/rr_mux4_stage.sv
// Round-robin arbiter driving a 4:1 mux select, with a
// one-entry registered valid/ready output stage.
module rr_mux4_stage
   import rr_mux4_stage_pkg::*;
#(
   parameter int SIZE    = 32,
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         in_valid,
   output logic [3:0]         in_ready,
   input  logic [SIZE-1:0]    a0,
   input  logic [SIZE-1:0]    a1,
   input  logic [SIZE-1:0]    a2,
   input  logic [SIZE-1:0]    a3,
   output logic [1:0]         sel,
   output logic [SIZE-1:0]    out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [1:0]         last_src,
   output logic [COUNT_W-1:0] xfer_cnt
);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [SEL_W-1:0]   src_q, src_d;
   logic [SIZE-1:0]    data_q, data_d;
   logic [COUNT_W-1:0] cnt_q, cnt_d;

   logic [SIZE-1:0]    mux_z;
   logic [SEL_W-1:0]   grant;
   logic [SEL_W-1:0]   idx;
   logic               found;
   logic               space;
   logic               load;

   // Scan from ptr upward; the first requester wins.
   always_comb begin
      grant = ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = ptr_q + k[SEL_W-1:0];
         if (!found && in_valid[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      space    = (state_q == ST_EMPTY) || out_ready;
      load     = !rst && space && found;
      sel      = load ? grant : ptr_q;
      in_ready = load ? (4'b0001 << grant) : 4'b0000;
   end

   yMux4to1 #(
      .SIZE(SIZE)
   ) u_mux (
      .z (mux_z),
      .a0(a0),
      .a1(a1),
      .a2(a2),
      .a3(a3),
      .c (sel)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      src_d   = src_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (load) begin
         state_d = ST_FULL;
         data_d  = mux_z;
         src_d   = sel;
         ptr_d   = next_idx(sel);
         cnt_d   = cnt_q + COUNT_W'(1);
      end else if (out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         ptr_q   <= PTR_RESET;
         src_q   <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         src_q   <= src_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign last_src  = src_q;
   assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_mux4_stage.sv
// Directed plus random bench for rr_mux4_stage against
// a plain-arithmetic model of the arbitration rules.
module tb_rr_mux4_stage;

   localparam int SIZE = 32;
   localparam int CW   = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      in_valid;
   logic [3:0]      in_ready;
   logic [SIZE-1:0] a0, a1, a2, a3;
   logic [1:0]      sel;
   logic [SIZE-1:0] out_data;
   logic            out_valid;
   logic            out_ready;
   logic [1:0]      last_src;
   logic [CW-1:0]   xfer_cnt;

   int vectors = 0;
   int miscompares = 0;

   // reference model state
   int      m_ptr, m_src, m_cnt;
   bit      m_valid;
   logic [31:0] m_data;

   rr_mux4_stage #(
      .SIZE(SIZE),
      .COUNT_W(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a0(a0),
      .a1(a1),
      .a2(a2),
      .a3(a3),
      .sel(sel),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .last_src(last_src),
      .xfer_cnt(xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_src = 0;
      m_cnt = 0;
      m_valid = 0;
      m_data = '0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
      chk({tag, ".data"}, out_data, m_data);
      chk({tag, ".src"}, {30'd0, last_src}, m_src[31:0]);
      chk({tag, ".cnt"}, {28'd0, xfer_cnt}, m_cnt[31:0]);
   endtask

   // Called at posedge+1; ends at the next posedge+1.
   task automatic step(input string tag, input logic [3:0] iv,
                       input logic ord, input bit rand_data);
      logic [31:0] w [4];
      int g;
      bit ld;
      if (rand_data) begin
         a0 = $urandom;
         a1 = $urandom;
         a2 = $urandom;
         a3 = $urandom;
      end
      in_valid  = iv;
      out_ready = ord;
      w[0] = a0;
      w[1] = a1;
      w[2] = a2;
      w[3] = a3;
      g = -1;
      for (int k = 3; k >= 0; k--)
         if (iv[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      ld = (!m_valid || ord) && (g >= 0);
      #4;
      chk({tag, ".rdy"}, {28'd0, in_ready},
          ld ? (32'd1 << g) : 32'd0);
      chk({tag, ".sel"}, {30'd0, sel}, ld ? g : m_ptr);
      @(posedge clk);
      if (ld) begin
         m_data  = w[g];
         m_valid = 1;
         m_src   = g;
         m_ptr   = (g + 1) % 4;
         m_cnt   = (m_cnt + 1) % 16;
      end else if (ord) begin
         m_valid = 0;
      end
      #1;
      check_regs(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [31:0] held;
      rst = 1'b1;
      in_valid = 4'b1111;
      out_ready = 1'b0;
      a0 = '0;
      a1 = '0;
      a2 = '0;
      a3 = '0;
      model_reset();
      @(posedge clk);
      #1;
      chk("rst.rdy", {28'd0, in_ready}, 32'd0);
      check_regs("rst");
      rst = 1'b0;

      // single source
      a2 = 32'hDEADBEEF;
      step("single", 4'b0100, 1'b1, 0);
      chk("single.lit", out_data, 32'hDEADBEEF);
      step("ptr3", 4'b0000, 1'b1, 0);
      chk("ptr3.sel", {30'd0, sel}, 32'd3);

      // round robin from reset
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step("rr", 4'b1111, 1'b1, 1);
         chk("rr.order", {30'd0, last_src}, i % 4);
      end
      chk("rr.cnt6", {28'd0, xfer_cnt}, 32'd6);

      // skip and wrap: get ptr to 3, then 0011
      step("to3", 4'b0100, 1'b1, 1);
      step("wrap0", 4'b0011, 1'b1, 1);
      chk("wrap0.src", {30'd0, last_src}, 32'd0);
      step("wrap1", 4'b0011, 1'b1, 1);
      chk("wrap1.src", {30'd0, last_src}, 32'd1);

      // backpressure
      held = out_data;
      for (int i = 0; i < 3; i++) begin
         step("bp", 4'b1111, 1'b0, 1);
         chk("bp.hold", out_data, held);
      end
      step("bp.rel", 4'b1111, 1'b1, 1);
      chk("bp.full", {31'd0, out_valid}, 32'd1);

      // async reset while holding a word
      rst = 1'b1;
      #1;
      chk("arst.rdy", {28'd0, in_ready}, 32'd0);
      model_reset();
      check_regs("arst");
      @(posedge clk);
      #1;
      check_regs("arst.hold");
      rst = 1'b0;
      step("arst.idle", 4'b0000, 1'b1, 1);

      // counter wrap
      do_reset();
      for (int i = 0; i < 17; i++)
         step("wrap", 4'b1111, 1'b1, 1);
      chk("wrap.cnt", {28'd0, xfer_cnt}, 32'd1);

      // random traffic
      for (int i = 0; i < 300; i++)
         step("rand", 4'($urandom), 1'($urandom_range(0, 3) != 0), 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
